// File: rtl/mfcc_pkg.sv
// Shared constants, state type and Hamming coefficient generator for the MFCC front end.
// The coefficients are derived by integer arithmetic, so the table is fixed at elaboration.
package mfcc_pkg;

    localparam int SAMPLE_WIDTH = 16;
    localparam int COEF_WIDTH   = 16;
    localparam int FRAME_SIZE   = 400;
    localparam int IDX_W        = $clog2(FRAME_SIZE);
    localparam int PROD_W       = SAMPLE_WIDTH + COEF_WIDTH + 1;

    localparam logic signed [PROD_W-1:0] Q15_ROUND = PROD_W'(2 ** 14);
    localparam logic signed [PROD_W-1:0] SAT_MAX   = PROD_W'(2 ** (SAMPLE_WIDTH - 1) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MIN   = -SAT_MAX - PROD_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} hamming_state_t;

    // Fixed point with 56 fractional bits; pi rounded at the last hex digit.
    localparam logic signed [127:0] FX_ONE = 128'sh0100_0000_0000_0000;
    localparam logic signed [127:0] PI_Q56 = 128'sh0324_3F6A_8885_A309;

    // w[n] = round(32768*(0.54 - 0.46*cos(2*pi*n/(FRAME_SIZE-1)))), capped at 0x7FFF.
    function automatic logic [COEF_WIDTH-1:0] hamming_coef(input int n);
        logic signed [127:0] x, x2, term, c, num, w;
        int m;
        m    = (2 * n > FRAME_SIZE - 1) ? (FRAME_SIZE - 1 - n) : n;
        x    = (PI_Q56 * 128'sd2 * 128'(m)) / 128'(FRAME_SIZE - 1);
        x2   = (x * x) >>> 56;
        term = FX_ONE;
        c    = FX_ONE;
        for (int k = 1; k <= 30; k++) begin
            term = (-((term * x2) >>> 56)) / 128'((2 * k - 1) * (2 * k));
            c    = c + term;
        end
        num = 128'sd32768 * (128'sd54 * FX_ONE - 128'sd46 * c) + 128'sd50 * FX_ONE;
        w   = num / (128'sd100 * FX_ONE);
        if (w > 128'sd32767) w = 128'sd32767;
        return w[COEF_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/hamming_window_if.sv
// Bundle of the window_buffer read port, FFT-side stream and frame control signals.
interface hamming_window_if;
    import mfcc_pkg::*;

    logic                    start_i;
    logic                    win_valid_i;
    logic                    win_rd_en_o;
    logic [SAMPLE_WIDTH-1:0] win_data_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [SAMPLE_WIDTH-1:0] out_data_o;
    logic                    out_last_o;
    logic                    start_move_o;
    logic                    busy_o;

    modport slave (
        input  start_i, win_valid_i, win_data_i, out_ready_i,
        output win_rd_en_o, out_valid_o, out_data_o, out_last_o, start_move_o, busy_o
    );

    modport master (
        output start_i, win_valid_i, win_data_i, out_ready_i,
        input  win_rd_en_o, out_valid_o, out_data_o, out_last_o, start_move_o, busy_o
    );
endinterface

// File: rtl/hamming_window_coef_rom.sv
// Hamming coefficient ROM with a registered read, so the coefficient lines up with window_buffer data.
module hamming_coef_rom
    import mfcc_pkg::*;
(
    input  logic                  clk,
    input  logic [IDX_W-1:0]      addr,
    output logic [COEF_WIDTH-1:0] coef
);
    logic [COEF_WIDTH-1:0] rom [FRAME_SIZE];

    generate
        for (genvar gi = 0; gi < FRAME_SIZE; gi++) begin : g_rom
            localparam logic [COEF_WIDTH-1:0] W = hamming_coef(gi);
            assign rom[gi] = W;
        end
    endgenerate

    always_ff @(posedge clk) begin
        coef <= rom[addr];
    end
endmodule

// File: rtl/hamming_window.sv
// Reads one frame from window_buffer, applies the Hamming window in Q1.15 and streams it
// through a 2-entry skid buffer; pulses start_move_o once the last sample is accepted.
module hamming_window
    import mfcc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    hamming_window_if.slave  bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_SIZE - 1);

    hamming_state_t          state_reg, state_next;
    logic [IDX_W-1:0]        rd_idx_reg;
    logic                    pend_reg, pend_last_reg;
    logic [SAMPLE_WIDTH-1:0] skid_data_reg [2];
    logic                    skid_last_reg [2];
    logic                    wr_ptr_reg, rd_ptr_reg;
    logic [1:0]              count_reg;

    logic [COEF_WIDTH-1:0]    coef;
    logic                     issue, pop;
    logic [1:0]               occupancy;
    logic signed [PROD_W-1:0] product, rounded;
    logic [SAMPLE_WIDTH-1:0]  result;

    hamming_coef_rom u_coef_rom (
        .clk  (clk),
        .addr (rd_idx_reg),
        .coef (coef)
    );

    // A pop in the same cycle frees a slot, which keeps one sample per cycle flowing.
    assign pop       = (count_reg != 2'd0) && bus.out_ready_i;
    assign occupancy = count_reg + {1'b0, pend_reg} - {1'b0, pop};

    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        case (state_reg)
            IDLE: if (bus.start_i && bus.win_valid_i) state_next = RUN;
            RUN: begin
                issue = bus.win_valid_i && (occupancy < 2'd2);
                if (issue && (rd_idx_reg == LAST_IDX)) state_next = DRAIN;
            end
            DRAIN: if (pop && skid_last_reg[rd_ptr_reg]) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        product = $signed({{(PROD_W - SAMPLE_WIDTH){bus.win_data_i[SAMPLE_WIDTH-1]}}, bus.win_data_i})
                * $signed({{(PROD_W - COEF_WIDTH){1'b0}}, coef});
        rounded = (product + Q15_ROUND) >>> 15;
        if (rounded > SAT_MAX) begin
            result = SAT_MAX[SAMPLE_WIDTH-1:0];
        end else if (rounded < SAT_MIN) begin
            result = SAT_MIN[SAMPLE_WIDTH-1:0];
        end else begin
            result = rounded[SAMPLE_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rd_idx_reg    <= '0;
            pend_reg      <= 1'b0;
            pend_last_reg <= 1'b0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            count_reg     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                skid_data_reg[i] <= '0;
                skid_last_reg[i] <= 1'b0;
            end
        end else begin
            state_reg     <= state_next;
            pend_reg      <= issue;
            pend_last_reg <= issue && (rd_idx_reg == LAST_IDX);
            if (issue) begin
                rd_idx_reg <= (rd_idx_reg == LAST_IDX) ? '0 : rd_idx_reg + 1'b1;
            end
            if (pend_reg) begin
                skid_data_reg[wr_ptr_reg] <= result;
                skid_last_reg[wr_ptr_reg] <= pend_last_reg;
                wr_ptr_reg                <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, pend_reg} - {1'b0, pop};
        end
    end

    assign bus.win_rd_en_o  = issue;
    assign bus.out_valid_o  = (count_reg != 2'd0);
    assign bus.out_data_o   = skid_data_reg[rd_ptr_reg];
    assign bus.out_last_o   = skid_last_reg[rd_ptr_reg];
    assign bus.start_move_o = (state_reg == DONE);
    assign bus.busy_o       = (state_reg != IDLE);
endmodule

// File: tb/tb_hamming_window.sv
// Frame-level bench for hamming_window: window_buffer is modelled in the stimulus, and every
// output is compared against a real-valued Hamming window model.
module tb_hamming_window;
    import mfcc_pkg::*;

    localparam real TB_PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_n;

    hamming_window_if bus ();

    hamming_window dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          coef_w [FRAME_SIZE];
    logic [15:0] frame  [FRAME_SIZE];
    int          exp_q  [FRAME_SIZE];
    int          got    [FRAME_SIZE];

    function automatic int model_coef(input int n);
        real v;
        int  r;
        v = 32768.0 * (0.54 - 0.46 * $cos(2.0 * TB_PI * real'(n) / real'(FRAME_SIZE - 1)));
        r = $rtoi($floor(v + 0.5));
        if (r > 32767) r = 32767;
        return r;
    endfunction

    function automatic int model_out(input int x, input int w);
        int y;
        y = $rtoi($floor((real'(x) * real'(w) + 16384.0) / 32768.0));
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    task automatic check(input string tag, input longint observed, input longint expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic expect_quiet(input string tag);
        #1;
        check({tag, ":out_valid"},  longint'(bus.out_valid_o), 0);
        check({tag, ":out_data"},   longint'(bus.out_data_o), 0);
        check({tag, ":out_last"},   longint'(bus.out_last_o), 0);
        check({tag, ":rd_en"},      longint'(bus.win_rd_en_o), 0);
        check({tag, ":start_move"}, longint'(bus.start_move_o), 0);
        check({tag, ":busy"},       longint'(bus.busy_o), 0);
    endtask

    task automatic fill(input int kind);
        for (int i = 0; i < FRAME_SIZE; i++) begin
            if (kind == 0) begin
                frame[i] = 16'h4000;
            end else if (kind == 1) begin
                frame[i] = 16'h8000;
            end else begin
                case ($urandom_range(0, 9))
                    0:       frame[i] = 16'h8000;
                    1:       frame[i] = 16'h7FFF;
                    default: frame[i] = 16'($urandom);
                endcase
            end
            exp_q[i] = model_out(int'($signed(frame[i])), coef_w[i]);
            got[i]   = 0;
        end
    endtask

    task automatic run_frame(input string name, input bit rand_ready, input int gap_at,
                             input int glitch_at, input int abort_at);
        int          issued    = 0;
        int          acc       = 0;
        int          cyc       = 0;
        int          first_cyc = -1;
        int          last_cyc  = -100;
        int          gap_left  = 0;
        bit          gap_used  = 1'b0;
        bit          rd_prev   = 1'b0;
        bit          prev_stall = 1'b0;
        bit          done      = 1'b0;
        logic [15:0] prev_data = '0;
        logic        prev_last = 1'b0;

        bus.start_i     = 1'b1;
        bus.win_valid_i = 1'b1;
        bus.out_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;

        while (!done && cyc < 3000) begin
            if (rd_prev) bus.win_data_i = frame[issued-1];
            if (gap_at >= 0 && !gap_used && issued == gap_at) begin
                gap_left = 10;
                gap_used = 1'b1;
            end
            bus.win_valid_i = (gap_left == 0);
            if (gap_left > 0) gap_left--;
            bus.out_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.start_i     = (cyc == glitch_at);
            #1;
            if (!bus.win_valid_i)
                check({name, ":rd_in_gap"}, longint'(bus.win_rd_en_o), 0);
            if (bus.win_rd_en_o)
                check({name, ":rd_in_frame"}, longint'(issued < FRAME_SIZE), 1);
            if (prev_stall) begin
                check({name, ":stall_valid"}, longint'(bus.out_valid_o), 1);
                check({name, ":stall_data"},  longint'(bus.out_data_o), longint'(prev_data));
                check({name, ":stall_last"},  longint'(bus.out_last_o), longint'(prev_last));
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (acc < FRAME_SIZE) begin
                    got[acc] = int'($signed(bus.out_data_o));
                    check({name, ":data"}, longint'(got[acc]), longint'(exp_q[acc]));
                    check({name, ":last"}, longint'(bus.out_last_o), longint'(acc == FRAME_SIZE - 1));
                end
                if (acc == 0) first_cyc = cyc;
                acc++;
                if (acc == FRAME_SIZE) last_cyc = cyc;
            end
            check({name, ":outstanding"}, longint'((issued + int'(bus.win_rd_en_o) - acc) <= 2), 1);
            check({name, ":start_move"}, longint'(bus.start_move_o), longint'(cyc == last_cyc + 1));
            if (cyc == last_cyc + 1) check({name, ":busy_T1"}, longint'(bus.busy_o), 1);
            if (cyc == last_cyc + 2) begin
                check({name, ":busy_T2"}, longint'(bus.busy_o), 0);
                done = 1'b1;
            end
            prev_stall = bus.out_valid_o && !bus.out_ready_i;
            prev_data  = bus.out_data_o;
            prev_last  = bus.out_last_o;
            if (bus.win_rd_en_o) issued++;
            rd_prev = bus.win_rd_en_o;

            if (abort_at >= 0 && acc == abort_at) begin
                rst_n = 1'b0;
                expect_quiet({name, ":in_reset"});
                bus.start_i     = 1'b0;
                bus.win_valid_i = 1'b1;
                @(posedge clk); #1;
                rst_n = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    expect_quiet({name, ":after_reset"});
                    @(posedge clk); #1;
                end
                return;
            end

            if (!done) begin
                @(posedge clk); #1;
                cyc++;
            end
        end

        check({name, ":frame_done"}, longint'(done), 1);
        check({name, ":reads"},      longint'(issued), FRAME_SIZE);
        check({name, ":outputs"},    longint'(acc), FRAME_SIZE);
        if (!rand_ready && gap_at < 0) begin
            check({name, ":latency"},     longint'(first_cyc), 2);
            check({name, ":consecutive"}, longint'(last_cyc - first_cyc), FRAME_SIZE - 1);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.start_i     = 1'b0;
        bus.win_valid_i = 1'b0;
        bus.win_data_i  = '0;
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < FRAME_SIZE; i++) coef_w[i] = model_coef(i);

        repeat (3) @(posedge clk);
        #1;
        expect_quiet("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_quiet("idle");

        // start_i without win_valid_i must not begin a frame
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        expect_quiet("start_no_valid");

        fill(0);
        run_frame("const4000", 1'b0, -1, -1, -1);
        check("const4000:out0",   longint'(got[0]), 1311);
        check("const4000:out199", longint'(got[199]), 16384);
        check("const4000:out399", longint'(got[399]), 1311);

        fill(1);
        run_frame("const8000", 1'b0, -1, -1, -1);
        check("const8000:out0",   longint'(got[0]), -2621);
        check("const8000:out199", longint'(got[199]), -32767);
        check("const8000:out399", longint'(got[399]), -2621);

        fill(2);
        run_frame("rand_ready", 1'b1, -1, -1, -1);

        fill(2);
        run_frame("start_glitch", 1'b0, -1, 100, -1);

        fill(2);
        run_frame("valid_gap", 1'b0, 150, -1, -1);

        fill(2);
        run_frame("abort", 1'b0, -1, -1, 200);
        fill(2);
        run_frame("after_abort", 1'b1, -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
